// File: rtl/bcd_down_counter_pkg.sv
// Shared types and constants for the BCD countdown timer.
package bcd_down_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Ceiling log2; clog2(1) is 0, so callers must floor the result at 1 bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_down_counter_lim_dec.sv
// One-digit BCD decrement with borrow; out-of-range digits saturate to 9.
module lim_dec
  import bcd_down_counter_pkg::*;
(
  input  logic [3:0] a,
  input  logic       bi,
  output logic [3:0] diff,
  output logic       bo
);

  always_comb begin
    diff = a;
    bo   = 1'b0;
    if (a > BCD_MAX) begin
      diff = BCD_MAX;
    end else if (bi) begin
      if (a == 4'd0) begin
        diff = BCD_MAX;
        bo   = 1'b1;
      end else begin
        diff = a - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer: preset load, prescaled decrement, stop at zero.
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  expired
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = (clog2(TICK_DIV) > 0) ? clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          expired_d;
  logic [CW-1:0] dec_value;
  logic [CW-1:0] clamp_value;
  logic [DIGITS:0] borrow;
  logic          borrow_unused;

  // Ripple-borrow decrement chain; the top borrow can never fire since zero is never decremented.
  assign borrow[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    lim_dec u_dec (
      .a   (count_q[4*g +: 4]),
      .bi  (borrow[g]),
      .diff(dec_value[4*g +: 4]),
      .bo  (borrow[g+1])
    );
  end
  assign borrow_unused = borrow[DIGITS];

  // Preset clamp: any non-decimal nibble becomes 9.
  always_comb begin
    clamp_value = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      clamp_value[4*i +: 4] = (load_value[4*i +: 4] > BCD_MAX) ? BCD_MAX : load_value[4*i +: 4];
    end
  end

  // Next-state, next-count and prescaler logic.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    presc_d   = presc_q;
    expired_d = 1'b0;
    if (load) begin
      count_d = clamp_value;
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (count_q != '0) begin
              state_d = ST_RUN;
              presc_d = '0;
            end else begin
              state_d   = ST_DONE;
              expired_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            count_d = dec_value;
            if (dec_value == '0) begin
              state_d   = ST_DONE;
              expired_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (pause) state_d = ST_RUN;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // busy/done are registered from the next state so they track the state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      presc_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      busy    <= (state_d == ST_RUN) || (state_d == ST_PAUSE);
      done    <= (state_d == ST_DONE);
      expired <= expired_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Scoreboard bench for bcd_down_counter (DIGITS=2, TICK_DIV=4) plus exhaustive lim_dec sweep.
module tb_bcd_down_counter;

  localparam int unsigned DIGITS   = 2;
  localparam int unsigned TICK_DIV = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  typedef struct packed {
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic       expired;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] count;
  logic       busy, done, expired;

  logic [3:0] ld_a;
  logic       ld_bi;
  logic [3:0] ld_diff;
  logic       ld_bo;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];

  int m_st = M_IDLE;
  int m_cnt = 0;
  int m_pre = 0;
  bit m_exp = 1'b0;

  bcd_down_counter #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .count(count), .busy(busy),
    .done(done), .expired(expired)
  );

  lim_dec u_lim (.a(ld_a), .bi(ld_bi), .diff(ld_diff), .bo(ld_bo));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int clamp_dec(input logic [7:0] v);
    int t, o;
    t = int'(v[7:4]);
    o = int'(v[3:0]);
    if (t > 9) t = 9;
    if (o > 9) o = 9;
    return t * 10 + o;
  endfunction

  // Reference model of one posedge, in decimal arithmetic.
  task automatic model(input logic rs, input logic ld, input logic [7:0] lv,
                       input logic st, input logic ps);
    m_exp = 1'b0;
    if (!rs) begin
      m_st = M_IDLE; m_cnt = 0; m_pre = 0;
    end else if (ld) begin
      m_cnt = clamp_dec(lv); m_st = M_IDLE; m_pre = 0;
    end else begin
      case (m_st)
        M_IDLE: if (st) begin
          if (m_cnt != 0) begin m_st = M_RUN; m_pre = 0; end
          else begin m_st = M_DONE; m_exp = 1'b1; end
        end
        M_RUN: begin
          if (ps) m_st = M_PAUSE;
          else if (m_pre == TICK_DIV - 1) begin
            m_pre = 0;
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin m_st = M_DONE; m_exp = 1'b1; end
          end else m_pre = m_pre + 1;
        end
        M_PAUSE: if (ps) m_st = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic rs, input logic ld, input logic [7:0] lv,
                      input logic st, input logic ps);
    exp_t e;
    reset = rs; load = ld; load_value = lv; start = st; pause = ps;
    model(rs, ld, lv, st, ps);
    e.cnt     = {4'(m_cnt / 10), 4'(m_cnt % 10)};
    e.busy    = (m_st == M_RUN) || (m_st == M_PAUSE);
    e.done    = (m_st == M_DONE);
    e.expired = m_exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("count", 32'(count), 32'(e.cnt));
    check("busy", 32'(busy), 32'(e.busy));
    check("done", 32'(done), 32'(e.done));
    check("expired", 32'(expired), 32'(e.expired));
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int cycles, pulses;
    logic [7:0] prev;

    // Reset state
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);

    // Full countdown from 12 with borrow across the tens digit
    step(1'b1, 1'b1, 8'h12, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    cycles = 0;
    pulses = 0;
    while (done !== 1'b1 && cycles < 200) begin
      prev = count;
      idle();
      cycles++;
      if (expired === 1'b1) pulses++;
      if (prev == 8'h10 && count != prev) check("borrow_10_09", 32'(count), 32'h09);
    end
    check("run_len", 32'(cycles), 32'd48);
    repeat (3) begin
      idle();
      if (expired === 1'b1) pulses++;
    end
    check("exp_pulses", 32'(pulses), 32'd1);
    check("done_hold_cnt", 32'(count), 32'h00);

    // Reset mid-run
    step(1'b1, 1'b1, 8'h37, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    repeat (9) idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("midrun_rst_cnt", 32'(count), 32'h00);
    check("midrun_rst_busy", 32'(busy), 32'd0);

    // Clamp and zero start
    step(1'b1, 1'b1, 8'hAF, 1'b0, 1'b0);
    check("clamp_af", 32'(count), 32'h99);
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    check("zero_start_exp", 32'(expired), 32'd1);
    check("zero_start_done", 32'(done), 32'd1);
    repeat (3) idle();

    // Pause holds count and prescaler
    step(1'b1, 1'b1, 8'h05, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    idle();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (10) begin
      idle();
      check("pause_hold", 32'(count), 32'h05);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    idle();
    check("resume_1", 32'(count), 32'h05);
    idle();
    check("resume_2", 32'(count), 32'h04);

    // load beats start; start/pause ignored in DONE
    step(1'b1, 1'b1, 8'h33, 1'b1, 1'b0);
    check("load_win_cnt", 32'(count), 32'h33);
    check("load_win_busy", 32'(busy), 32'd0);
    step(1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (5) idle();
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    check("done_ignore", 32'(done), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic rs, ld, st, ps;
      rs = ($urandom_range(0, 79) != 0);
      ld = ($urandom_range(0, 29) == 0);
      st = ($urandom_range(0, 7) == 0);
      ps = ($urandom_range(0, 11) == 0);
      step(rs, ld, 8'($urandom), st, ps);
    end

    // Exhaustive single-digit decrement
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 2; b++) begin
        ld_a = 4'(a);
        ld_bi = 1'(b);
        #1;
        if (a >= 10) begin
          check("lim_dec_sat", 32'(ld_diff), 32'd9);
        end else if (a == 0 && b == 1) begin
          check("lim_dec_wrap_d", 32'(ld_diff), 32'd9);
          check("lim_dec_wrap_b", 32'(ld_bo), 32'd1);
        end else begin
          check("lim_dec_d", 32'(ld_diff), 32'(a - b));
          check("lim_dec_b", 32'(ld_bo), 32'd0);
        end
      end
    end

    if (n_errors == 0) $display("Test Passed - %m");
    else $display("Test Failed - %m");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
